lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the data memory (2^ADDR_W 32-bit words).
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_valid in 1 request present; req_ready out 1 request accepted when both high.
REQ-005 SHALL have ports: req_read in 1, req_write in 1, req_funct3 in 3 (RV32I load/store funct3), req_addr in 32 byte address, req_wdata in 32 store data.
REQ-006 SHALL have ports: rsp_valid out 1 one-cycle completion pulse; rsp_rdata out 32 load result; rsp_err out 1 request rejected.
REQ-007 SHALL have ports: mem_en out 1, mem_we out 1, mem_addr out ADDR_W word index, mem_wdata out 32, mem_rdata in 32 (registered read, valid the cycle after a read edge).

Function
REQ-008 SHALL implement FSM states IDLE, READ, WAIT, WRITE, RESP; req_ready=1 only in IDLE.
REQ-009 IDLE, on req_valid: SHALL latch the request; illegal -> RESP with err; lw/lb/lh/lbu/lhu or sb/sh -> READ; sw -> WRITE.
REQ-010 Illegal SHALL mean: read and write both high, or neither; load funct3 in {3,6,7}; store funct3 >= 3.
REQ-011 READ SHALL drive mem_en=1, mem_we=0, mem_addr=addr[ADDR_W+1:2]; next WAIT.
REQ-012 WAIT, load: SHALL register the result into rsp_rdata; next RESP.
REQ-013 WAIT, sb/sh: SHALL merge store bytes into mem_rdata; next WRITE.
REQ-014 WRITE SHALL drive mem_en=1, mem_we=1, mem_addr as REQ-011, mem_wdata=merged word (sw: req_wdata unmodified); next RESP.
REQ-015 RESP SHALL assert rsp_valid for exactly one cycle, then go to IDLE; there is no response backpressure.
REQ-016 Byte lane SHALL be k=addr[1:0] (little-endian); halfword lane h=addr[1].
REQ-017 lb/lbu SHALL return byte k sign/zero-extended; lh/lhu SHALL return halfword h sign/zero-extended; lw SHALL return the full word.
REQ-018 sb SHALL replace only byte k; sh SHALL replace only halfword h; other bytes keep their read values.
REQ-019 Latency, acceptance edge to rsp_valid high: lw/lb/lh/lbu/lhu 3 cycles, sw 2 cycles, sb/sh 4 cycles, illegal or trapped 1 cycle.
REQ-020 Outside READ/WRITE: mem_en=0, mem_we=0; errored requests SHALL never touch memory.
REQ-021 rsp_rdata SHALL hold its value until the next load completes; SHALL be 0 on error responses; rsp_err SHALL be valid only with rsp_valid.
REQ-022 Address bits above ADDR_W+1 SHALL be ignored (word index wraps modulo 2^ADDR_W).
REQ-023 req_* inputs SHALL be ignored outside IDLE; latched values SHALL be used for the whole operation.

Reset
REQ-024 rst_n low SHALL force IDLE and zero all outputs and internal registers, except req_ready, which is 1 as IDLE requires (REQ-008).
REQ-025 Reset mid-operation SHALL abort it; no write, and no rsp_valid, SHALL occur for the aborted request after release.

Configuration
REQ-026 Macro LSU_MISALIGN_TRAP_EN defined: misaligned access SHALL go to RESP with rsp_err=1, no memory access. Misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0.
REQ-027 Macro undefined: misaligned addresses SHALL be aligned down (halfword clears addr[0], word clears addr[1:0]) and executed normally, rsp_err=0.

Verification
REQ-028 Memory word 5 = 0x8081_F2F3: lb addr 0x15 -> rsp_rdata 0xFFFF_FFF2 three cycles after acceptance. lbu addr 0x17 -> 0x0000_0080.
REQ-029 Memory word 5 = 0x1122_3344: sb addr 0x16, wdata 0xAB -> READ, WAIT, WRITE sequence, word becomes 0x11AB_3344, rsp_valid 4 cycles after acceptance.
REQ-030 sw addr 0x20, wdata 0xDEAD_BEEF -> single write to word 8, rsp_valid 2 cycles after acceptance; lw addr 0x20 then returns 0xDEAD_BEEF.
REQ-031 lw addr 0x22: with LSU_MISALIGN_TRAP_EN -> rsp_err=1, no mem_en. Without it -> word 8 read, rsp_err=0.
REQ-032 Illegal requests: funct3=3 load, or read and write both high -> rsp_err=1 after 1 cycle, mem_en stays 0.
REQ-033 rst_n pulsed low during WAIT of an sh -> memory unchanged, no rsp_valid; next request accepted immediately after release.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: RV32I loads/stores against a single-port registered-read word memory; LSU_MISALIGN_TRAP_EN makes misaligned accesses error instead of aligning down.
// Latency: lw/lb/lh/lbu/lhu 3, sw 2, sb/sh 4, rejected 1 cycle; one request in flight, req_ready only when idle, no response backpressure.
module lsu #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [2:0]        funct3;
    logic [ADDR_W+1:0] addr;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q;
  logic        err_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        illegal_op;
  logic        req_err;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Address bits above the memory word index are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    illegal_op = (req_read == req_write)
              || (req_read  && ((req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7)))
              || (req_write && (req_funct3 >= 3'd3));
`ifdef LSU_MISALIGN_TRAP_EN
    req_err = illegal_op
           || ((req_funct3[1:0] == 2'b01) && req_addr[0])
           || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    req_err = illegal_op;
`endif
  end

  // Halfword lane uses addr[1] only, so misaligned halfwords align down for free.
  always_comb begin
    lane_b = mem_rdata[{req_q.addr[1:0], 3'b000} +: 8];
    lane_h = req_q.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (req_q.funct3)
      3'd0:    load_val = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_val = {{16{lane_h[15]}}, lane_h};
      3'd4:    load_val = {24'd0, lane_b};
      3'd5:    load_val = {16'd0, lane_h};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (req_q.funct3[0])
      merged[{req_q.addr[1], 4'b0000} +: 16] = wdata_q[15:0];
    else
      merged[{req_q.addr[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                                state_nxt = RESP;
          else if (req_write && (req_funct3 == 3'd2)) state_nxt = WRITE;
          else                                        state_nxt = READ;
        end
      end
      READ:    state_nxt = WAIT;
      WAIT:    state_nxt = req_q.wr ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      READ: begin
        mem_en   = 1'b1;
        mem_addr = req_q.addr[ADDR_W+1:2];
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = req_q.addr[ADDR_W+1:2];
        mem_wdata = wdata_q;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  // wdata_q starts as the raw store data and becomes the merged word for sb/sh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        req_q.wr     <= req_write;
        req_q.funct3 <= req_funct3;
        req_q.addr   <= req_addr[ADDR_W+1:0];
        err_q        <= req_err;
        wdata_q      <= req_wdata;
        if (req_err) rdata_q <= '0;
      end
      if (state == WAIT) begin
        if (req_q.wr) wdata_q <= merged;
        else          rdata_q <= load_val;
      end
    end
  end

  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stimulus pushes expected responses to a scoreboard, a negedge monitor pops and compares.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  lsu #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_wr = 0;

  logic [31:0] tmem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = 8'd0;
  logic [31:0] pre_data = 32'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_we) tmem[pre_addr] <= pre_data;
    if (mem_en) begin
      n_acc <= n_acc + 1;
      if (mem_we) begin
        tmem[mem_addr] <= mem_wdata;
        n_wr <= n_wr + 1;
      end else begin
        mem_rdata <= tmem[mem_addr];
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          acc_cyc;
    int          acc_base;
  } exp_t;
  exp_t sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_err && !rsp_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_err_without_valid at cycle %0d", cyc);
    end
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp at cycle %0d: rdata %h err %b", cyc, rsp_rdata, rsp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("latency", cyc - e.acc_cyc, e.lat);
        chk("mem_accesses", n_acc - e.acc_base, e.acc);
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] x_rdata, input logic x_err,
                       input int x_lat, input int x_acc);
    exp_t e;
    bit   done;
    @(negedge clk);
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_funct3 = f3; req_addr = addr; req_wdata = wd;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    e.rdata = x_rdata; e.err = x_err; e.lat = x_lat; e.acc = x_acc;
    e.acc_cyc = cyc; e.acc_base = n_acc;
    sb.push_back(e);
    #1;
    // Scramble the request bus: the DUT must work from its latched copy.
    req_valid = 1'b0; req_read = ~rd; req_write = ~wr;
    req_funct3 = ~f3; req_addr = ~addr; req_wdata = ~wd;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_timeout: no response within 20 cycles for addr %h", addr);
      sb.delete();
    end
  endtask

  logic [31:0] w5_after_sh;
  int          wr_snap;

  initial begin
    for (int i = 0; i < 256; i++) tmem[i] = 32'd0;
    mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_mem_en", {31'd0, mem_en}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;

    poke(8'd5, 32'h8081_F2F3);
    issue(1, 0, 3'd0, 32'h15, 0, 32'hFFFF_FFF2, 0, 3, 1);
    issue(1, 0, 3'd4, 32'h17, 0, 32'h0000_0080, 0, 3, 1);
    issue(1, 0, 3'd1, 32'h16, 0, 32'hFFFF_8081, 0, 3, 1);
    issue(1, 0, 3'd5, 32'h14, 0, 32'h0000_F2F3, 0, 3, 1);
    issue(1, 0, 3'd2, 32'h14, 0, 32'h8081_F2F3, 0, 3, 1);

    // Stores leave rsp_rdata at the last load value.
    poke(8'd5, 32'h1122_3344);
    issue(0, 1, 3'd0, 32'h16, 32'h0000_00AB, 32'h8081_F2F3, 0, 4, 2);
    chk("sb_word5", tmem[5], 32'h11AB_3344);

    if (TRAP) begin
      issue(0, 1, 3'd1, 32'h15, 32'h0000_CAFE, 32'h0, 1, 1, 0);
      w5_after_sh = 32'h11AB_3344;
    end else begin
      issue(0, 1, 3'd1, 32'h15, 32'h0000_CAFE, 32'h8081_F2F3, 0, 4, 2);
      w5_after_sh = 32'h11AB_CAFE;
    end
    chk("sh_word5", tmem[5], w5_after_sh);

    issue(0, 1, 3'd2, 32'h20, 32'hDEAD_BEEF, TRAP ? 32'h0 : 32'h8081_F2F3, 0, 2, 1);
    chk("sw_word8", tmem[8], 32'hDEAD_BEEF);
    issue(1, 0, 3'd2, 32'h20, 0, 32'hDEAD_BEEF, 0, 3, 1);

    if (TRAP) issue(1, 0, 3'd2, 32'h22, 0, 32'h0, 1, 1, 0);
    else      issue(1, 0, 3'd2, 32'h22, 0, 32'hDEAD_BEEF, 0, 3, 1);

    wr_snap = n_wr;
    issue(1, 0, 3'd3, 32'h20, 0, 32'h0, 1, 1, 0);
    issue(1, 1, 3'd2, 32'h20, 32'h1, 32'h0, 1, 1, 0);
    issue(0, 0, 3'd2, 32'h20, 32'h1, 32'h0, 1, 1, 0);
    issue(0, 1, 3'd3, 32'h20, 32'h1, 32'h0, 1, 1, 0);
    issue(1, 0, 3'd6, 32'h20, 0, 32'h0, 1, 1, 0);
    chk("illegal_no_write", n_wr - wr_snap, 0);
    chk("illegal_word8", tmem[8], 32'hDEAD_BEEF);

    // Upper address bits wrap onto word 5.
    issue(1, 0, 3'd2, 32'h0000_0414, 0, w5_after_sh, 0, 3, 1);

    // Reset during WAIT of an sh aborts it.
    poke(8'd3, 32'h5566_7788);
    wr_snap = n_wr;
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
    req_funct3 = 3'd1; req_addr = 32'h0C; req_wdata = 32'h0000_1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    rst_n = 1'b1;
    chk("rst_release_ready", {31'd0, req_ready}, 32'd1);
    issue(1, 0, 3'd2, 32'h0C, 0, 32'h5566_7788, 0, 3, 1);
    chk("abort_no_write", n_wr - wr_snap, 0);
    chk("abort_word3", tmem[3], 32'h5566_7788);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
